// File: rtl/pc_stack.sv
// -----------------------------------------------------------------------------
// pc_stack
//   Program counter and hardware return stack for a PIC16C5x-style core.
//   The PC is the program-memory fetch address. It advances once per
//   instruction cycle, at the Q4 clock edge. GOTO, CALL, RETLW and writes to
//   PCL can replace that increment with a branch target. CALL pushes the
//   current PC onto a shallow return stack. RETLW pops the stack back into
//   the PC. Skips are not handled here: the instruction register turns the
//   fetched word into a NOP, and the PC advances as it normally would.
//
// Ports
//   clk             clock
//   rst             synchronous reset, active-high; takes priority over all
//                   other inputs in every phase
//   qPhase          sequencer phase: 0=Q1 1=Q2 2=Q3 3=Q4
//   goto/call/retlw/pclWrite
//                   decode of the executing instruction, sampled at Q4
//   instrK          9-bit literal field of the executing instruction
//   aluOut          ALU result, used as the new PCL value on a PCL write
//   pageSel         page-select bits (PA) from STATUS
//   programMemAddr  current PC, which is the fetch address
//   pcl             PC[7:0], read back as the PCL register
//   stackDepth      number of valid stack entries, saturating
//   stackOverflow   one-clock pulse after a push onto a full stack
//   stackUnderflow  one-clock pulse after a pop from an empty stack
// -----------------------------------------------------------------------------
module pc_stack #(
  parameter int                     PC_WIDTH     = 11,
  parameter int                     STACK_DEPTH  = 2,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = {PC_WIDTH{1'b1}},
  localparam int                    PAGE_W       = PC_WIDTH - 9,
  localparam int                    DEPTH_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          qPhase,
  input  logic                goto,
  input  logic                call,
  input  logic                retlw,
  input  logic                pclWrite,
  input  logic [8:0]          instrK,
  input  logic [7:0]          aluOut,
  input  logic [PAGE_W-1:0]   pageSel,
  output logic [PC_WIDTH-1:0] programMemAddr,
  output logic [7:0]          pcl,
  output logic [DEPTH_W-1:0]  stackDepth,
  output logic                stackOverflow,
  output logic                stackUnderflow
);

  localparam logic [1:0]         PHASE_Q4   = 2'd3;
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  // Registered state
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [DEPTH_W-1:0]  depth_q;
  logic                ovf_q;
  logic                unf_q;

  // Next-state values
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];
  logic [DEPTH_W-1:0]  depth_d;
  logic                ovf_d;
  logic                unf_d;

  logic q4;
  logic full;
  logic empty;

  assign q4    = (qPhase == PHASE_Q4);
  assign full  = (depth_q == DEPTH_FULL);
  assign empty = (depth_q == '0);

  // Next-state logic. Updates happen only at Q4. The decode inputs are
  // expected to be one-hot. If more than one is high, the order of the
  // if/else chain below decides which one takes effect.
  always_comb begin
    // NOTE: every output of this block gets a hold/default value first, so no
    // path leaves a signal unassigned and no latch is inferred.
    pc_d    = pc_q;
    stack_d = stack_q;
    depth_d = depth_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    if (q4) begin
      if (goto) begin
        pc_d = {pageSel, instrK};
      end else if (call) begin
        pc_d = {pageSel, 1'b0, instrK[7:0]};
        // Push. The PC already points past the CALL, so it is the return
        // address. When the stack is full, the deepest entry falls off the
        // bottom.
        for (int i = STACK_DEPTH - 1; i > 0; i--) begin
          stack_d[i] = stack_q[i-1];
        end
        stack_d[0] = pc_q;
        if (full) ovf_d   = 1'b1;
        else      depth_d = depth_q + DEPTH_W'(1);
      end else if (retlw) begin
        // Pop. The deepest entry keeps its value, so it is duplicated upward.
        // A pop from an empty stack still returns whatever is in stack[0].
        pc_d = stack_q[0];
        for (int i = 0; i < STACK_DEPTH - 1; i++) begin
          stack_d[i] = stack_q[i+1];
        end
        if (empty) unf_d   = 1'b1;
        else       depth_d = depth_q - DEPTH_W'(1);
      end else if (pclWrite) begin
        pc_d = {pageSel, 1'b0, aluOut};
      end else begin
        // The increment wraps modulo 2^PC_WIDTH, so RESET_VECTOR steps to 0.
        pc_d = pc_q + PC_WIDTH'(1);
      end
    end
  end

  // State register. The flags are reloaded on every clock, so each one is
  // high for exactly the clock that follows the Q4 edge that set it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      // NOTE: the return stack is small, and its power-up contents are
      // visible through an underflowing RETLW. For that reason it is
      // explicitly cleared on reset, unlike a RAM-style memory.
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      stack_q <= stack_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign programMemAddr = pc_q;
  assign pcl            = pc_q[7:0];
  assign stackDepth     = depth_q;
  assign stackOverflow  = ovf_q;
  assign stackUnderflow = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// -----------------------------------------------------------------------------
// tb_pc_stack
//   Directed test of pc_stack with PC_WIDTH=11 and STACK_DEPTH=2.
//   The stimulus side drives the inputs and steps the clock. After each edge
//   it queues the state it expects the DUT to show. The expected values are
//   worked out by hand for every instruction. A separate monitor process runs
//   on the falling edge: it pops each queued expectation and compares it with
//   the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pc_stack;

  logic        clk;
  logic        rst;
  logic [1:0]  qPhase;
  logic        goto, call, retlw, pclWrite;
  logic [8:0]  instrK;
  logic [7:0]  aluOut;
  logic [1:0]  pageSel;
  logic [10:0] programMemAddr;
  logic [7:0]  pcl;
  logic [1:0]  stackDepth;
  logic        stackOverflow;
  logic        stackUnderflow;

  pc_stack #(.PC_WIDTH(11), .STACK_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .qPhase         (qPhase),
    .goto           (goto),
    .call           (call),
    .retlw          (retlw),
    .pclWrite       (pclWrite),
    .instrK         (instrK),
    .aluOut         (aluOut),
    .pageSel        (pageSel),
    .programMemAddr (programMemAddr),
    .pcl            (pcl),
    .stackDepth     (stackDepth),
    .stackOverflow  (stackOverflow),
    .stackUnderflow (stackUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] pc;
    logic [1:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Expected architectural state before the next instruction is applied
  logic [10:0] cur_pc;
  logic [1:0]  cur_d;

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
  endtask

  // Monitor: consumes expectations on the falling edge, away from the
  // active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, "addr",  32'(programMemAddr), 32'(e.pc));
        check(e.name, "pcl",   32'(pcl),            32'(e.pc[7:0]));
        check(e.name, "depth", 32'(stackDepth),     32'(e.depth));
        check(e.name, "ovf",   32'(stackOverflow),  32'(e.ovf));
        check(e.name, "unf",   32'(stackUnderflow), 32'(e.unf));
      end
    end
  end

  // Advance one clock, then queue the state expected just after that edge.
  task automatic tick(input string name, input logic [10:0] pc,
                      input logic [1:0] d, input logic o, input logic u);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = name; e.pc = pc; e.depth = d; e.ovf = o; e.unf = u;
    sb.push_back(e);
  endtask

  task automatic clear_ins();
    goto = 1'b0; call = 1'b0; retlw = 1'b0; pclWrite = 1'b0;
    instrK = '0; aluOut = '0; pageSel = '0;
  endtask

  // One full instruction cycle (Q1..Q4). The decode inputs are held for all
  // four phases. Q1-Q3 must leave the PC and depth unchanged with both flags
  // low. After Q4 the hand-computed new state must appear.
  task automatic instr(input string name, input logic g, input logic c,
                       input logic r, input logic p, input logic [8:0] k,
                       input logic [7:0] alu, input logic [1:0] ps,
                       input logic [10:0] new_pc, input logic [1:0] new_d,
                       input logic o, input logic u);
    goto = g; call = c; retlw = r; pclWrite = p;
    instrK = k; aluOut = alu; pageSel = ps;
    for (int ph = 0; ph < 4; ph++) begin
      qPhase = 2'(ph);
      if (ph == 3) tick(name, new_pc, new_d, o, u);
      else         tick(name, cur_pc, cur_d, 1'b0, 1'b0);
    end
    cur_pc = new_pc;
    cur_d  = new_d;
    clear_ins();
  endtask

  task automatic nop(input string name, input logic [10:0] new_pc);
    instr(name, 0, 0, 0, 0, 9'h000, 8'h00, 2'b00, new_pc, cur_d, 0, 0);
  endtask

  task automatic set_pc(input logic [10:0] a);
    instr("set_pc", 1, 0, 0, 0, a[8:0], 8'h00, a[10:9], a, cur_d, 0, 0);
  endtask

  initial begin
    clear_ins();
    rst    = 1'b1;
    qPhase = 2'd3;
    goto   = 1'b1;                       // reset must win over a Q4 goto

    // 1. Reset, then count up from the wrapped reset vector
    tick("rst0", 11'h7FF, 2'd0, 0, 0);
    tick("rst1", 11'h7FF, 2'd0, 0, 0);
    rst = 1'b0;
    clear_ins();
    cur_pc = 11'h7FF;
    cur_d  = 2'd0;
    nop("wrap_rv", 11'h000);
    nop("inc1",    11'h001);
    nop("inc2",    11'h002);
    nop("inc3",    11'h003);

    // 2. A goto seen only in Q2 is ignored; a goto held through Q4 jumps
    set_pc(11'h010);
    qPhase = 2'd0; tick("goto_q2", cur_pc, cur_d, 0, 0);
    goto = 1'b1; instrK = 9'h155; pageSel = 2'b10;
    qPhase = 2'd1; tick("goto_q2", cur_pc, cur_d, 0, 0);
    clear_ins();
    qPhase = 2'd2; tick("goto_q2", cur_pc, cur_d, 0, 0);
    qPhase = 2'd3; tick("goto_q2", 11'h011, cur_d, 0, 0);
    cur_pc = 11'h011;
    instr("goto", 1, 0, 0, 0, 9'h155, 8'h00, 2'b10, 11'h555, 2'd0, 0, 0);

    // 3. Call and return
    set_pc(11'h013);
    instr("call",  0, 1, 0, 0, 9'h1A3, 8'h00, 2'b01, 11'h2A3, 2'd1, 0, 0);
    instr("retlw", 0, 0, 1, 0, 9'h000, 8'h00, 2'b00, 11'h013, 2'd0, 0, 0);

    // 4. Overflow on the third call; underflow on the third return
    set_pc(11'h101);
    instr("callA", 0, 1, 0, 0, 9'h000, 8'h00, 2'b00, 11'h000, 2'd1, 0, 0);
    set_pc(11'h202);
    instr("callB", 0, 1, 0, 0, 9'h000, 8'h00, 2'b00, 11'h000, 2'd2, 0, 0);
    set_pc(11'h303);
    instr("callC_ovf", 0, 1, 0, 0, 9'h000, 8'h00, 2'b00, 11'h000, 2'd2, 1, 0);
    instr("ret1",      0, 0, 1, 0, 9'h000, 8'h00, 2'b00, 11'h303, 2'd1, 0, 0);
    instr("ret2",      0, 0, 1, 0, 9'h000, 8'h00, 2'b00, 11'h202, 2'd0, 0, 0);
    instr("ret3_unf",  0, 0, 1, 0, 9'h000, 8'h00, 2'b00, 11'h202, 2'd0, 0, 1);

    // 5. PCL write; goto beats call; plain increment wraps at the top
    set_pc(11'h3FE);
    instr("pclw",      0, 0, 0, 1, 9'h000, 8'h7C, 2'b11, 11'h67C, 2'd0, 0, 0);
    instr("goto_call", 1, 1, 0, 0, 9'h0AB, 8'h00, 2'b00, 11'h0AB, 2'd0, 0, 0);
    instr("ret_pclw",  0, 0, 1, 1, 9'h000, 8'h55, 2'b00, 11'h202, 2'd0, 0, 1);
    set_pc(11'h7FF);
    nop("wrap_top", 11'h000);

    // 6. Reset during Q2 with a full stack
    set_pc(11'h111);
    instr("callD", 0, 1, 0, 0, 9'h022, 8'h00, 2'b00, 11'h022, 2'd1, 0, 0);
    instr("callE", 0, 1, 0, 0, 9'h033, 8'h00, 2'b00, 11'h033, 2'd2, 0, 0);
    call = 1'b1; instrK = 9'h044;
    qPhase = 2'd0; tick("rst_mid", 11'h033, 2'd2, 0, 0);
    rst = 1'b1;
    qPhase = 2'd1; tick("rst_mid", 11'h7FF, 2'd0, 0, 0);
    rst = 1'b0;
    clear_ins();
    qPhase = 2'd2; tick("rst_mid", 11'h7FF, 2'd0, 0, 0);
    qPhase = 2'd3; tick("rst_mid", 11'h000, 2'd0, 0, 0);
    cur_pc = 11'h000;
    cur_d  = 2'd0;
    // The stack was cleared by reset, so an underflowing return yields 0
    set_pc(11'h055);
    instr("ret_after_rst", 0, 0, 1, 0, 9'h000, 8'h00, 2'b00, 11'h000, 2'd0, 0, 1);

    // Let the monitor drain, then confirm nothing was left unchecked
    repeat (2) @(negedge clk);
    #1;
    check("scoreboard", "pending", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
